mult_share_sched: RTL

Round-robin scheduler that shares one sequential signed multiplier among N_REQ requesters. It accepts one operand pair at a time over per-requester valid/ready handshakes, sequences the multiplier with a start pulse, and waits for its done flag. It returns the 2·WIDTH-bit product tagged with the requester index. A watchdog flags a multiplier that never completes. It sits between the multiplier and the client blocks of the adders-multipliers chip.

---
 rtl/mult_share_sched.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin arbiter sharing one sequential signed
// multiplier among N_REQ requesters, with a completion watchdog.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   req_valid/ready    per-requester handshake (req_ready one-hot, IDLE only)
//   req_a, req_b       packed operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid/ready   result handshake
//   resp_id/p/err      owner index, product (0 on timeout), watchdog flag
//   mul_start          one-cycle start pulse to the multiplier
//   mul_a, mul_b       operands held from ISSUE through WAIT
//   mul_done, mul_p    multiplier completion and product (sampled in WAIT)
module mult_share_sched #(
  parameter  int unsigned N_REQ   = 4,
  parameter  int unsigned WIDTH   = 32,
  parameter  int unsigned TIMEOUT = 255,
  localparam int unsigned IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [2*WIDTH-1:0]     resp_p,
  output logic                   resp_err,
  output logic                   mul_start,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  input  logic                   mul_done,
  input  logic [2*WIDTH-1:0]     mul_p
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t               state, state_d;
  logic [IDW-1:0]       rr_ptr, rr_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [WIDTH-1:0]     a_d, b_d;
  logic [IDW-1:0]       id_d;
  logic [2*WIDTH-1:0]   p_d;
  logic                 err_d, rv_d, start_d;
  logic                 found;
  logic [IDW-1:0]       gidx;

  // First valid requester at or after ptr, wrapping; MSB flags a hit.
  function automatic logic [IDW:0] pick(input logic [N_REQ-1:0] v,
                                        input logic [IDW-1:0]   ptr);
    logic [IDW:0] r;
    int unsigned  j;
    r = '0;
    // Scan downward so the smallest offset from ptr is the last writer.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = (32'(ptr) + unsigned'(i)) % N_REQ;
      if (v[j]) r = {1'b1, IDW'(j)};
    end
    return r;
  endfunction

  assign {found, gidx} = pick(req_valid, rr_ptr);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      cnt        <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      resp_id    <= '0;
      resp_p     <= '0;
      resp_err   <= 1'b0;
      resp_valid <= 1'b0;
      mul_start  <= 1'b0;
    end else begin
      state      <= state_d;
      rr_ptr     <= rr_d;
      cnt        <= cnt_d;
      mul_a      <= a_d;
      mul_b      <= b_d;
      resp_id    <= id_d;
      resp_p     <= p_d;
      resp_err   <= err_d;
      resp_valid <= rv_d;
      mul_start  <= start_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d   = state;
    rr_d      = rr_ptr;
    cnt_d     = cnt;
    a_d       = mul_a;
    b_d       = mul_b;
    id_d      = resp_id;
    p_d       = resp_p;
    err_d     = resp_err;
    rv_d      = resp_valid;
    start_d   = 1'b0;
    req_ready = '0;

    unique case (state)
      S_IDLE: begin
        // rst qualifies the grant so nothing is accepted while held in reset.
        if (rst && found) begin
          req_ready = N_REQ'(1) << gidx;
          a_d       = req_a[32'(gidx) * WIDTH +: WIDTH];
          b_d       = req_b[32'(gidx) * WIDTH +: WIDTH];
          id_d      = gidx;
          rr_d      = (gidx == IDW'(N_REQ - 1)) ? '0 : IDW'(gidx + 1'b1);
          start_d   = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done) begin
          p_d     = mul_p;
          err_d   = 1'b0;
          rv_d    = 1'b1;
          state_d = S_RESP;
        end else if (cnt == CW'(TIMEOUT)) begin
          p_d     = '0;
          err_d   = 1'b1;
          rv_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          rv_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
